// File: rtl/smoothing_sched_pkg.sv
// smoothing_sched shared types: FSM states, window-select codes
// and the win_sel -> tap-count mapping used for win_full.
package smoothing_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    SETTLE,
    LOAD,
    FLUSH
  } state_t;

  localparam logic [1:0] WIN_1  = 2'b00;
  localparam logic [1:0] WIN_2  = 2'b01;
  localparam logic [1:0] WIN_4  = 2'b10;
  localparam logic [1:0] WIN_16 = 2'b11;

  function automatic logic [7:0] win_taps(
    input logic [1:0] sel
  );
    logic [7:0] t;
    unique case (sel)
      WIN_1:   t = 8'd1;
      WIN_2:   t = 8'd2;
      WIN_4:   t = 8'd4;
      default: t = 8'd16;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/smoothing_sched_if.sv
// smoothing_sched bus: reader/vsync/switch inputs and datapath
// controls. slave = scheduler side, master = surrounding system.
interface smoothing_sched_if #(
  parameter int DATA_W   = 16,
  parameter int MAX_LOG2 = 4
);
  logic [DATA_W-1:0] data_x;
  logic [DATA_W-1:0] data_y;
  logic              data_update;
  logic              v_sync;
  logic [1:0]        win_sel;
  logic [DATA_W-1:0] smp_x;
  logic [DATA_W-1:0] smp_y;
  logic              shift_en;
  logic              win_clr;
  logic              out_load;
  logic              win_full;
  logic [MAX_LOG2:0] fill_cnt;
  logic [7:0]        stale_cnt;

  modport master (
    output data_x, data_y, data_update,
    output v_sync, win_sel,
    input  smp_x, smp_y, shift_en,
    input  win_clr, out_load, win_full,
    input  fill_cnt, stale_cnt
  );

  modport slave (
    input  data_x, data_y, data_update,
    input  v_sync, win_sel,
    output smp_x, smp_y, shift_en,
    output win_clr, out_load, win_full,
    output fill_cnt, stale_cnt
  );
endinterface

// File: rtl/smoothing_sched_edge_sync.sv
// edge_sync: 2-flop synchronizer plus a history flop.
// Ports: clk, reset (async high), d (async level), pulse (1-clk rise).
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);
  logic [2:0] q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else       q <= {q[1:0], d};
  end

  assign pulse = q[1] & ~q[2];
endmodule

// File: rtl/smoothing_sched.sv
// smoothing_sched: per-frame shift/settle/load sequencer for the
// accelerometer moving-average window.
// Ports: clk, reset (async high), bus (smoothing_sched_if.slave).
// Build option SMOOTHING_STALE_HOLD_EN: skip the shift on stale frames.
module smoothing_sched
  import smoothing_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int MAX_LOG2 = 4
) (
  input logic              clk,
  input logic              reset,
  smoothing_sched_if.slave bus
);
  localparam int CW = MAX_LOG2 + 1;
  localparam logic [CW-1:0] FILL_MAX = CW'(1 << MAX_LOG2);

  state_t            state, nstate;
  logic              du_edge, vs_edge;
  logic              sel_chg, do_shift;
  logic [1:0]        sel_q;
  logic              new_flag;
  logic              frame_pend, flush_pend;
  logic [DATA_W-1:0] pend_x, pend_y;
  logic [CW-1:0]     fill_q, taps;
  logic [7:0]        stale_q;

  edge_sync u_du (
    .clk   (clk),
    .reset (reset),
    .d     (bus.data_update),
    .pulse (du_edge)
  );

  edge_sync u_vs (
    .clk   (clk),
    .reset (reset),
    .d     (bus.v_sync),
    .pulse (vs_edge)
  );

  assign sel_chg = bus.win_sel != sel_q;
  assign taps    = CW'(win_taps(bus.win_sel));

`ifdef SMOOTHING_STALE_HOLD_EN
  assign do_shift = (state == SHIFT) && new_flag;
`else
  assign do_shift = (state == SHIFT);
`endif

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (sel_chg)
          nstate = FLUSH;
        else if (vs_edge || frame_pend)
          nstate = SHIFT;
      end
      SHIFT:  nstate = SETTLE;
      SETTLE: nstate = LOAD;
      LOAD: begin
        if (flush_pend || sel_chg)
          nstate = FLUSH;
        else
          nstate = IDLE;
      end
      FLUSH:   nstate = IDLE;
      default: nstate = FLUSH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FLUSH;
    else       state <= nstate;
  end

  // History tracks the live switch so a setting made during
  // reset is not seen as a change afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sel_q <= bus.win_sel;
    else       sel_q <= bus.win_sel;
  end

  // A frame edge not taken straight from IDLE waits here;
  // a further edge while one is already waiting is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_pend <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      if (state == IDLE && nstate == SHIFT)
        frame_pend <= 1'b0;
      else if (vs_edge)
        frame_pend <= 1'b1;
      if (nstate == FLUSH)
        flush_pend <= 1'b0;
      else if (sel_chg &&
               state inside {SHIFT, SETTLE, LOAD})
        flush_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_x   <= '0;
      pend_y   <= '0;
      new_flag <= 1'b0;
      fill_q   <= '0;
      stale_q  <= '0;
    end else begin
      // A capture in the SHIFT cycle wins over the clear so
      // that sample is still shifted on the next frame.
      if (du_edge) begin
        pend_x   <= bus.data_x;
        pend_y   <= bus.data_y;
        new_flag <= 1'b1;
      end else if (state == SHIFT) begin
        new_flag <= 1'b0;
      end
      if (state == FLUSH) begin
        fill_q  <= '0;
        stale_q <= '0;
      end else if (state == SHIFT) begin
        if (do_shift && fill_q != FILL_MAX)
          fill_q <= fill_q + 1'b1;
        if (new_flag)
          stale_q <= '0;
        else if (stale_q != 8'hff)
          stale_q <= stale_q + 8'd1;
      end
    end
  end

  assign bus.smp_x     = pend_x;
  assign bus.smp_y     = pend_y;
  assign bus.shift_en  = do_shift;
  assign bus.win_clr   = (state == FLUSH) && !reset;
  assign bus.out_load  = (state == LOAD);
  assign bus.win_full  = fill_q >= taps;
  assign bus.fill_cnt  = fill_q;
  assign bus.stale_cnt = stale_q;
endmodule

// File: tb/tb_smoothing_sched.sv
// tb_smoothing_sched: frame table plus corner sequences; expected
// window-head samples are queued at v_sync and popped on shift_en.
module tb_smoothing_sched;
`ifdef SMOOTHING_STALE_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } smp_t;

  typedef struct {
    logic        upd;
    logic [15:0] x;
    logic [15:0] y;
    logic        e_shift;
    logic [4:0]  e_fill;
    logic [7:0]  e_stale;
    logic        e_full;
  } vec_t;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_shift = 0;
  smp_t sb[$];
  logic [15:0] last_x = '0;
  logic [15:0] last_y = '0;
  vec_t tv[8];

  smoothing_sched_if #(.DATA_W(16), .MAX_LOG2(4)) bus ();

  smoothing_sched #(.DATA_W(16), .MAX_LOG2(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h",
               nm, act, exp);
    end
  endtask

  // Scoreboard side: every shift_en must match the oldest
  // expected head sample.
  always @(negedge clk) begin
    if (!reset && bus.shift_en) begin
      smp_t e;
      n_shift++;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL shift_unexpected: got smp_x 0x%0h, want none",
                 bus.smp_x);
      end else begin
        e = sb.pop_front();
        chk("smp_x", 32'(bus.smp_x), 32'(e.x));
        chk("smp_y", 32'(bus.smp_y), 32'(e.y));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_for(input bit is_load, output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (is_load ? bus.out_load : bus.shift_en) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: no %s, want one within 40 clk",
               is_load ? "out_load" : "shift_en");
    end
  endtask

  task automatic send_sample(input logic [15:0] x,
                             input logic [15:0] y);
    bus.data_x = x;
    bus.data_y = y;
    bus.data_update = 1'b1;
    tick(4);
    bus.data_update = 1'b0;
    tick(3);
    last_x = x;
    last_y = y;
  endtask

  task automatic run_frame(input logic upd,
                           input logic [15:0] x,
                           input logic [15:0] y,
                           input logic exp_sh);
    int t0, ts, tl, n0;
    if (upd) send_sample(x, y);
    n0 = n_shift;
    if (exp_sh) sb.push_back({last_x, last_y});
    bus.v_sync = 1'b1;
    t0 = cyc;
    if (exp_sh) begin
      wait_for(1'b0, ts);
      if (ts >= 0) chk("shift_lat", 32'(ts - t0), 32'd3);
    end
    wait_for(1'b1, tl);
    if (tl >= 0) chk("load_lat", 32'(tl - t0), 32'd5);
    chk("shift_cnt", 32'(n_shift - n0), 32'(exp_sh));
    tick(1);
    bus.v_sync = 1'b0;
    tick(3);
  endtask

  initial begin
    int ts, tl;
    int exp_fill;
    tv[0] = '{1'b1, 16'h0010, 16'h0110, 1'b1, 5'd1, 8'd0, 1'b0};
    tv[1] = '{1'b1, 16'h0020, 16'h0120, 1'b1, 5'd2, 8'd0, 1'b0};
    tv[2] = '{1'b1, 16'h0030, 16'h0130, 1'b1, 5'd3, 8'd0, 1'b0};
    tv[3] = '{1'b1, 16'h0040, 16'h0140, 1'b1, 5'd4, 8'd0, 1'b1};
    tv[4] = '{1'b0, 16'h0000, 16'h0000, !HOLD,
              HOLD ? 5'd4 : 5'd5, 8'd1, 1'b1};
    tv[5] = '{1'b0, 16'h0000, 16'h0000, !HOLD,
              HOLD ? 5'd4 : 5'd6, 8'd2, 1'b1};
    tv[6] = '{1'b0, 16'h0000, 16'h0000, !HOLD,
              HOLD ? 5'd4 : 5'd7, 8'd3, 1'b1};
    tv[7] = '{1'b1, 16'h0050, 16'h0150, 1'b1,
              HOLD ? 5'd5 : 5'd8, 8'd0, 1'b1};

    bus.data_x = '0;
    bus.data_y = '0;
    bus.data_update = 1'b0;
    bus.v_sync = 1'b0;
    bus.win_sel = 2'b10;
    reset = 1'b1;
    tick(2);
    chk("rst_shift_en", 32'(bus.shift_en), 32'd0);
    chk("rst_win_clr", 32'(bus.win_clr), 32'd0);
    chk("rst_out_load", 32'(bus.out_load), 32'd0);
    chk("rst_fill", 32'(bus.fill_cnt), 32'd0);
    chk("rst_stale", 32'(bus.stale_cnt), 32'd0);
    chk("rst_full", 32'(bus.win_full), 32'd0);
    chk("rst_smp_x", 32'(bus.smp_x), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_clr", 32'(bus.win_clr), 32'd1);
    @(negedge clk);
    chk("post_rst_clr_end", 32'(bus.win_clr), 32'd0);
    tick(1);

    for (int i = 0; i < 8; i++) begin
      run_frame(tv[i].upd, tv[i].x, tv[i].y, tv[i].e_shift);
      chk("tbl_fill", 32'(bus.fill_cnt), 32'(tv[i].e_fill));
      chk("tbl_stale", 32'(bus.stale_cnt), 32'(tv[i].e_stale));
      chk("tbl_full", 32'(bus.win_full), 32'(tv[i].e_full));
    end

    // Select 16 taps in IDLE: flush, then fill to saturation.
    bus.win_sel = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("sel_idle_clr", 32'(bus.win_clr), 32'd1);
    tick(2);
    chk("sel_idle_fill", 32'(bus.fill_cnt), 32'd0);
    chk("sel_idle_full", 32'(bus.win_full), 32'd0);
    exp_fill = 0;
    for (int i = 0; i < 17; i++) begin
      run_frame(1'b1, 16'(16'h0100 + i), 16'(16'h0200 + i), 1'b1);
      exp_fill = (exp_fill < 16) ? exp_fill + 1 : 16;
      chk("sat_fill", 32'(bus.fill_cnt), 32'(exp_fill));
      chk("sat_full", 32'(bus.win_full), 32'(exp_fill >= 16));
    end

    // 11 -> 01 during SETTLE: LOAD completes, then FLUSH.
    send_sample(16'h0aaa, 16'h0bbb);
    sb.push_back({last_x, last_y});
    bus.v_sync = 1'b1;
    wait_for(1'b0, ts);
    tick(1);
    bus.win_sel = 2'b01;
    @(negedge clk);
    @(negedge clk);
    chk("settle_load", 32'(bus.out_load), 32'd1);
    @(negedge clk);
    chk("settle_clr", 32'(bus.win_clr), 32'd1);
    @(negedge clk);
    chk("settle_clr_once", 32'(bus.win_clr), 32'd0);
    chk("settle_fill", 32'(bus.fill_cnt), 32'd0);
    chk("settle_full", 32'(bus.win_full), 32'd0);
    tick(1);
    bus.v_sync = 1'b0;
    tick(3);

    // Frame edge 1 clk after SHIFT, reaching IDLE directly.
    send_sample(16'h0b0b, 16'h1b1b);
    sb.push_back({last_x, last_y});
    bus.v_sync = 1'b1;
    wait_for(1'b0, ts);
    bus.v_sync = 1'b0;
    tick(1);
    bus.v_sync = 1'b1;
    bus.data_x = 16'h0c0c;
    bus.data_y = 16'h1c1c;
    bus.data_update = 1'b1;
    last_x = 16'h0c0c;
    last_y = 16'h1c1c;
    sb.push_back({last_x, last_y});
    wait_for(1'b1, tl);
    wait_for(1'b0, ts);
    if (tl >= 0 && ts >= 0)
      chk("late_vs_gap", 32'(ts - tl), 32'd2);
    wait_for(1'b1, tl);
    tick(1);
    bus.v_sync = 1'b0;
    bus.data_update = 1'b0;
    tick(3);

    // Frame edge detected during LOAD: held until IDLE.
    send_sample(16'h0d0d, 16'h1d1d);
    sb.push_back({last_x, last_y});
    bus.v_sync = 1'b1;
    tick(1);
    bus.v_sync = 1'b0;
    tick(2);
    bus.v_sync = 1'b1;
    bus.data_x = 16'h0e0e;
    bus.data_y = 16'h1e1e;
    bus.data_update = 1'b1;
    last_x = 16'h0e0e;
    last_y = 16'h1e1e;
    sb.push_back({last_x, last_y});
    wait_for(1'b1, tl);
    wait_for(1'b0, ts);
    if (tl >= 0 && ts >= 0)
      chk("pend_vs_gap", 32'(ts - tl), 32'd2);
    wait_for(1'b1, tl);
    tick(1);
    bus.v_sync = 1'b0;
    bus.data_update = 1'b0;
    tick(3);

    // New sample edge in the SHIFT cycle itself.
    send_sample(16'h1234, 16'h4321);
    sb.push_back({last_x, last_y});
    bus.v_sync = 1'b1;
    tick(1);
    bus.data_x = 16'h5678;
    bus.data_y = 16'h8765;
    bus.data_update = 1'b1;
    wait_for(1'b1, tl);
    chk("coll_stale", 32'(bus.stale_cnt), 32'd0);
    tick(1);
    bus.v_sync = 1'b0;
    bus.data_update = 1'b0;
    tick(3);
    last_x = 16'h5678;
    last_y = 16'h8765;
    run_frame(1'b0, 16'h0000, 16'h0000, 1'b1);
    chk("coll_next_stale", 32'(bus.stale_cnt), 32'd0);

    // Reset in the middle of LOAD.
    send_sample(16'h0f0f, 16'h1f1f);
    sb.push_back({last_x, last_y});
    bus.v_sync = 1'b1;
    wait_for(1'b1, tl);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_load", 32'(bus.out_load), 32'd0);
    chk("mid_rst_shift", 32'(bus.shift_en), 32'd0);
    chk("mid_rst_clr", 32'(bus.win_clr), 32'd0);
    chk("mid_rst_fill", 32'(bus.fill_cnt), 32'd0);
    chk("mid_rst_stale", 32'(bus.stale_cnt), 32'd0);
    chk("mid_rst_smp_x", 32'(bus.smp_x), 32'd0);
    chk("mid_rst_full", 32'(bus.win_full), 32'd0);
    bus.v_sync = 1'b0;
    tick(2);
    reset = 1'b0;
    @(negedge clk);
    chk("rel_clr", 32'(bus.win_clr), 32'd1);
    chk("rel_fill", 32'(bus.fill_cnt), 32'd0);
    @(negedge clk);
    chk("rel_clr_once", 32'(bus.win_clr), 32'd0);
    tick(4);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
